wb_write_arbiter: RTL and testbench

Writeback arbiter that shares the register file's two write ports among `N_REQ` result producers (ALUs, load unit, multiplier, and so on).
- Each cycle it picks up to two valid results in round-robin order and never lets two grants target the same physical register.
- It registers the winners onto the write-port signals and broadcasts wakeup tags for the issue scoreboard.
- It sits between the functional-unit result buses and `register_file`, whose write ports it drives directly.

---
 rtl/wb_write_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: shares the register file's two write ports among
// N_REQ result producers. Up to two results are granted per cycle in
// round-robin order, never two to the same nonzero physical register.
// Winners are registered onto the write ports and mirrored as wakeup tags.
//
// Handshake: a requester holds valid/addr/data stable until it sees
// ready; a result is accepted in the cycle where valid && ready are both
// high. Ready is a combinational function of the valid inputs and the
// round-robin pointer, and is forced low while reset is asserted.
module wb_write_arbiter #(
  parameter int N_REQ   = 4,   // 2..8 requesters
  parameter int P_REG_W = 7,   // physical register tag width (p_reg)
  parameter int WORD_W  = 32   // result data width (word)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid  [0:N_REQ-1],
  input  logic [P_REG_W-1:0]  i_req_addr   [0:N_REQ-1],
  input  logic [WORD_W-1:0]   i_req_data   [0:N_REQ-1],
  output logic                o_req_ready  [0:N_REQ-1],
  output logic                o_w_en       [0:1],
  output logic [P_REG_W-1:0]  o_w_addr     [0:1],
  output logic [WORD_W-1:0]   o_w_data     [0:1],
  output logic                o_wake_valid [0:1],
  output logic [P_REG_W-1:0]  o_wake_tag   [0:1],
  output logic [31:0]         o_stall_cnt
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_REQ + 1);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_next;
  logic [31:0]        stall_cnt;

  logic               g0_hit, g1_hit;
  logic [P_REG_W-1:0] g0_addr, g1_addr;
  logic [WORD_W-1:0]  g0_data, g1_data;
  logic [CNT_W-1:0]   valid_cnt, grant_cnt;

  int                 scan_idx;
  int                 next_idx;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   last_sel;

  // Round-robin scan: first valid wins slot 0, next non-colliding valid wins slot 1.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) o_req_ready[i] = 1'b0;
    g0_hit    = 1'b0;
    g1_hit    = 1'b0;
    g0_addr   = '0;
    g1_addr   = '0;
    g0_data   = '0;
    g1_data   = '0;
    valid_cnt = '0;
    scan_idx  = 0;
    next_idx  = 0;
    sel       = '0;
    last_sel  = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      sel = PTR_W'(scan_idx);
      if (!i_rst && i_req_valid[sel]) begin
        valid_cnt = valid_cnt + CNT_W'(1);
        if (!g0_hit) begin
          g0_hit           = 1'b1;
          g0_addr          = i_req_addr[sel];
          g0_data          = i_req_data[sel];
          o_req_ready[sel] = 1'b1;
          last_sel         = sel;
        end else if (!g1_hit &&
                     ((i_req_addr[sel] != g0_addr) || (i_req_addr[sel] == '0))) begin
          // Address 0 is hardwired zero, so two writes to it cannot collide.
          g1_hit           = 1'b1;
          g1_addr          = i_req_addr[sel];
          g1_data          = i_req_data[sel];
          o_req_ready[sel] = 1'b1;
          last_sel         = sel;
        end
      end
    end
    grant_cnt = CNT_W'(g0_hit) + CNT_W'(g1_hit);
    next_idx  = int'(last_sel) + 1;
    if (next_idx >= N_REQ) next_idx = 0;
    rr_next   = PTR_W'(next_idx);
  end

  // Register the winners onto the write ports, advance the pointer, count stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr    <= '0;
      stall_cnt <= '0;
      for (int s = 0; s < 2; s++) begin
        o_w_en[s]   <= 1'b0;
        o_w_addr[s] <= '0;
        o_w_data[s] <= '0;
      end
    end else begin
      // A write to register 0 consumes the port but never enables it.
      o_w_en[0] <= g0_hit && (g0_addr != '0);
      o_w_en[1] <= g1_hit && (g1_addr != '0);
      if (g0_hit) begin
        o_w_addr[0] <= g0_addr;
        o_w_data[0] <= g0_data;
      end
      if (g1_hit) begin
        o_w_addr[1] <= g1_addr;
        o_w_data[1] <= g1_data;
      end
      if (g0_hit || g1_hit) rr_ptr <= rr_next;
      if ((valid_cnt > grant_cnt) && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Wakeup tags mirror the registered write ports.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      o_wake_valid[s] = o_w_en[s];
      o_wake_tag[s]   = o_w_addr[s];
    end
  end

  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, round-robin, address
// conflict, address 0, single requester and stall counter saturation.
module tb_wb_write_arbiter;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        req_valid  [0:N-1];
  logic [6:0]  req_addr   [0:N-1];
  logic [31:0] req_data   [0:N-1];
  logic        req_ready  [0:N-1];
  logic        w_en       [0:1];
  logic [6:0]  w_addr     [0:1];
  logic [31:0] w_data     [0:1];
  logic        wake_valid [0:1];
  logic [6:0]  wake_tag   [0:1];
  logic [31:0] stall_cnt;

  int n_cmp;
  int n_fail;

  wb_write_arbiter #(.N_REQ(N), .P_REG_W(7), .WORD_W(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_w_en       (w_en),
    .o_w_addr     (w_addr),
    .o_w_data     (w_data),
    .o_wake_valid (wake_valid),
    .o_wake_tag   (wake_tag),
    .o_stall_cnt  (stall_cnt)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ready_vec();
    return {req_ready[3], req_ready[2], req_ready[1], req_ready[0]};
  endfunction

  task automatic set_req(input int i, input logic v, input logic [6:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i]  = a;
    req_data[i]  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 7'd0, 32'd0);
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 7'd5, 32'hA0);
    set_req(1, 1'b1, 7'd6, 32'hA1);
    set_req(2, 1'b1, 7'd7, 32'hA2);
    set_req(3, 1'b1, 7'd8, 32'hA3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ready_vec() !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ready cyc %0d: got %b want 0000", c, ready_vec());
      end
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({w_en[1], w_en[0]} !== 2'b00 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: w_en %b%b stall %0d want 00 / 0", w_en[1], w_en[0], stall_cnt);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_release_grant: got %b want 0011", ready_vec());
    end
    step();
    n_cmp++;
    if (w_addr[0] !== 7'd5 || w_addr[1] !== 7'd6 || stall_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL reset_release_write: addr %0d/%0d stall %0d want 5/6 1", w_addr[0], w_addr[1], stall_cnt);
    end
  endtask

  // rr_ptr is 2 on entry; all four requesters remain valid.
  task automatic test_round_robin();
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b1100) begin
      n_fail++;
      $display("FAIL rr_grant_23: got %b want 1100", ready_vec());
    end
    step();
    n_cmp++;
    if (w_addr[0] !== 7'd7 || w_addr[1] !== 7'd8 || w_data[0] !== 32'hA2 || w_data[1] !== 32'hA3 ||
        w_en[0] !== 1'b1 || w_en[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_write_23: addr %0d/%0d data %h/%h en %b%b want 7/8 a2/a3 11",
               w_addr[0], w_addr[1], w_data[0], w_data[1], w_en[0], w_en[1]);
    end
    n_cmp++;
    if (wake_valid[0] !== 1'b1 || wake_valid[1] !== 1'b1 || wake_tag[0] !== 7'd7 || wake_tag[1] !== 7'd8) begin
      n_fail++;
      $display("FAIL rr_wake_23: valid %b%b tag %0d/%0d want 11 7/8", wake_valid[0], wake_valid[1], wake_tag[0], wake_tag[1]);
    end
    n_cmp++;
    if (stall_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL rr_stall_a: got %0d want 2", stall_cnt);
    end
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0011) begin
      n_fail++;
      $display("FAIL rr_grant_01: got %b want 0011", ready_vec());
    end
    step();
    clear_reqs();
    n_cmp++;
    if (w_addr[0] !== 7'd5 || w_addr[1] !== 7'd6 || stall_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL rr_write_01: addr %0d/%0d stall %0d want 5/6 3", w_addr[0], w_addr[1], stall_cnt);
    end
  endtask

  // rr_ptr is 2 on entry; requester 3 alone.
  task automatic test_single();
    set_req(3, 1'b1, 7'd127, 32'hFFFF_FFFF);
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 1000", ready_vec());
    end
    step();
    clear_reqs();
    n_cmp++;
    if (w_en[0] !== 1'b1 || w_en[1] !== 1'b0 || w_addr[0] !== 7'd127 || w_data[0] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL single_write: en %b%b addr %0d data %h want 10 127 ffffffff", w_en[0], w_en[1], w_addr[0], w_data[0]);
    end
    n_cmp++;
    if (stall_cnt !== 32'd3 || dut.rr_ptr !== 2'd0) begin
      n_fail++;
      $display("FAIL single_state: stall %0d rr_ptr %0d want 3 0", stall_cnt, dut.rr_ptr);
    end
  endtask

  // rr_ptr is 0 on entry: 0 and 1 collide on reg 9, 2 takes slot 1.
  task automatic test_addr_conflict();
    set_req(0, 1'b1, 7'd9, 32'h11);
    set_req(1, 1'b1, 7'd9, 32'h22);
    set_req(2, 1'b1, 7'd4, 32'h44);
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0101) begin
      n_fail++;
      $display("FAIL conflict_grant: got %b want 0101", ready_vec());
    end
    step();
    set_req(0, 1'b0, 7'd0, 32'd0);
    set_req(2, 1'b0, 7'd0, 32'd0);
    n_cmp++;
    if (w_addr[0] !== 7'd9 || w_data[0] !== 32'h11 || w_addr[1] !== 7'd4 || w_data[1] !== 32'h44 ||
        w_en[0] !== 1'b1 || w_en[1] !== 1'b1 || stall_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL conflict_write_a: p0 %0d/%h p1 %0d/%h en %b%b stall %0d want 9/11 4/44 11 4",
               w_addr[0], w_data[0], w_addr[1], w_data[1], w_en[0], w_en[1], stall_cnt);
    end
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0010) begin
      n_fail++;
      $display("FAIL conflict_retry_grant: got %b want 0010", ready_vec());
    end
    step();
    clear_reqs();
    n_cmp++;
    if (w_addr[0] !== 7'd9 || w_data[0] !== 32'h22 || w_en[0] !== 1'b1 || w_en[1] !== 1'b0 ||
        w_addr[1] !== 7'd4 || stall_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL conflict_write_b: p0 %0d/%h en %b%b p1addr %0d stall %0d want 9/22 10 4 4",
               w_addr[0], w_data[0], w_en[0], w_en[1], w_addr[1], stall_cnt);
    end
  endtask

  // rr_ptr is 2 on entry.
  task automatic test_addr_zero();
    set_req(0, 1'b1, 7'd0, 32'hDEAD);
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_grant: got %b want 0001", ready_vec());
    end
    step();
    clear_reqs();
    n_cmp++;
    if (w_en[0] !== 1'b0 || wake_valid[0] !== 1'b0 || w_addr[0] !== 7'd0 || w_data[0] !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL zero_write: en %b wake %b addr %0d data %h want 0 0 0 dead", w_en[0], wake_valid[0], w_addr[0], w_data[0]);
    end
    // rr_ptr now 1: two writes to reg 0 do not count as a collision.
    set_req(0, 1'b1, 7'd0, 32'h1);
    set_req(1, 1'b1, 7'd0, 32'h2);
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0011) begin
      n_fail++;
      $display("FAIL zero_pair_grant: got %b want 0011", ready_vec());
    end
    step();
    clear_reqs();
    n_cmp++;
    if (w_en[0] !== 1'b0 || w_en[1] !== 1'b0 || w_data[0] !== 32'h2 || w_data[1] !== 32'h1 || stall_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL zero_pair_write: en %b%b data %h/%h stall %0d want 00 2/1 4", w_en[0], w_en[1], w_data[0], w_data[1], stall_cnt);
    end
  endtask

  task automatic test_saturation();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    #1;
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL sat_preload: got %h want fffffffe", stall_cnt);
    end
    set_req(0, 1'b1, 7'd20, 32'h1);
    set_req(1, 1'b1, 7'd21, 32'h2);
    set_req(2, 1'b1, 7'd22, 32'h3);
    set_req(3, 1'b1, 7'd23, 32'h4);
    step();
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sat_first: got %h want ffffffff", stall_cnt);
    end
    step();
    step();
    clear_reqs();
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got %h want ffffffff", stall_cnt);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clear_reqs();
    test_reset();
    test_round_robin();
    test_single();
    test_addr_conflict();
    test_addr_zero();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
